// File: rtl/gonso_seq_if.sv
// gonso sequencer bus: register-block controls, SRAM port 1 and byte stream.
// slave = sequencer side, master = register block / SRAM / consumer side.
interface gonso_seq_if #(
  parameter int ASIZE = 32
);
  logic             controller_en;
  logic             start;
  logic [3:0]       w_count;
  logic [ASIZE-1:0] w_first;
  logic [ASIZE-1:0] w_last;
  logic             progress;
  logic             done;
  logic             err;
  logic             cs1_n;
  logic [ASIZE-1:0] addr1;
  logic [7:0]       rdata1;
  logic [7:0]       data_o;
  logic             valid_o;
  logic             last_o;
  logic             ready_i;

  modport slave (
    input  controller_en, start, w_count,
    input  w_first, w_last, rdata1, ready_i,
    output progress, done, err, cs1_n,
    output addr1, data_o, valid_o, last_o
  );

  modport master (
    output controller_en, start, w_count,
    output w_first, w_last, rdata1, ready_i,
    input  progress, done, err, cs1_n,
    input  addr1, data_o, valid_o, last_o
  );
endinterface

// File: rtl/gonso_sequencer.sv
// gonso playback sequencer: replays an SRAM byte window w_count times
// onto a valid/ready stream, one byte per FETCH/CAPTURE/OUT round.
module gonso_sequencer #(
  parameter int ASIZE = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  gonso_seq_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [ASIZE-1:0] first_q, first_d;
  logic [ASIZE-1:0] last_q, last_d;
  logic [ASIZE-1:0] ptr_q, ptr_d;
  logic [3:0]       count_q, count_d;
  logic [3:0]       pass_q, pass_d;
  logic [7:0]       data_q, data_d;
  logic             lastb_q, lastb_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      first_q <= '0;
      last_q  <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      pass_q  <= '0;
      data_q  <= '0;
      lastb_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      pass_q  <= pass_d;
      data_q  <= data_d;
      lastb_q <= lastb_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    pass_d  = pass_q;
    data_d  = data_q;
    lastb_d = lastb_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.controller_en && bus.start) begin
          if (bus.w_count == 4'd0) begin
            done_d = 1'b1;
          end else if (bus.w_last < bus.w_first) begin
            err_d = 1'b1;
          end else begin
            first_d = bus.w_first;
            last_d  = bus.w_last;
            count_d = bus.w_count;
            ptr_d   = bus.w_first;
            pass_d  = 4'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        data_d  = bus.rdata1;
        lastb_d = (ptr_q == last_q) && (pass_q == count_q);
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.ready_i) begin
          if (lastb_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (ptr_q == last_q) begin
            ptr_d   = first_q;
            pass_d  = pass_q + 4'd1;
            state_d = S_FETCH;
          end else begin
            ptr_d   = ptr_q + ASIZE'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a final handshake.
    if (state_q != S_IDLE && !bus.controller_en) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      ptr_d   = ptr_q;
      pass_d  = pass_q;
      data_d  = data_q;
      lastb_d = lastb_q;
    end
  end

  always_comb begin
    bus.progress = (state_q != S_IDLE);
    bus.cs1_n    = (state_q != S_FETCH);
    bus.valid_o  = (state_q == S_OUT);
    bus.addr1    = ptr_q;
    bus.data_o   = data_q;
    bus.last_o   = lastb_q;
    bus.done     = done_q;
    bus.err      = err_q;
  end
endmodule
